tug_key_arbiter: RTL

- Front-end controller between the two player inputs and the tug-of-war score/light logic.
- Left = human key, right = computer-player press pulse.
- Synchronizes both raw inputs, converts each press into at most one single-cycle move pulse, and arbitrates simultaneous presses.
- Enforces a hold-off window after every accepted move and freezes all moves once the game is over.

---
 rtl/tug_key_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/tug_key_arbiter.sv
// Tug-of-war input front end: synchronizes the two player keys, turns each fresh
// press into a single move/tie pulse, then enforces a hold-off window and a game-over freeze.
module tug_key_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic Reset,
  input  logic key,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] vld_pipe;
  logic                   prev_q;
  logic                   arm_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // vld_pipe marks which stages hold real samples; the reset zeros in the chain
  // must not arm the key, or a key held through reset release would fire.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      sync_q   <= '0;
      vld_pipe <= '0;
      prev_q   <= 1'b0;
      arm_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], key};
      vld_pipe <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
      prev_q   <= s;
      arm_q    <= arm_q | (vld_pipe[SYNC_STAGES-1] & ~s);
    end
  end

  assign rise = s & ~prev_q & arm_q;
endmodule

module tug_key_arbiter #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF     = 4
) (
  input  logic clk,
  input  logic Reset,
  input  logic key_l,
  input  logic key_r,
  input  logic enable,
  input  logic game_over,
  output logic move_left,
  output logic move_right,
  output logic tie,
  output logic busy
);
  localparam int NUM_KEYS = 2;

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  logic [NUM_KEYS-1:0] keys;
  logic [NUM_KEYS-1:0] rise;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ml_q, ml_d, mr_q, mr_d, tie_q, tie_d;

  assign keys = {key_r, key_l};

  // lane 0 = left (human), lane 1 = right (computer)
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    tug_key_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .Reset (Reset),
      .key   (keys[i]),
      .rise  (rise[i])
    );
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ml_q    <= 1'b0;
      mr_q    <= 1'b0;
      tie_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ml_q    <= ml_d;
      mr_q    <= mr_d;
      tie_q   <= tie_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ml_d    = 1'b0;
    mr_d    = 1'b0;
    tie_d   = 1'b0;
    if (game_over) begin
      state_d = DONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable && (|rise)) begin
            state_d = HOLD;
            cnt_d   = 8'(HOLDOFF - 1);
            tie_d   = rise[0] & rise[1];
            ml_d    = rise[0] & ~rise[1];
            mr_d    = rise[1] & ~rise[0];
          end
        end
        HOLD: begin
          if (cnt_q == 8'd0) state_d = IDLE;
          else               cnt_d   = cnt_q - 8'd1;
        end
        DONE: begin
          // restart handshake: scoring clears game_over while the game is disabled
          if (!enable) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign move_left  = ml_q;
  assign move_right = mr_q;
  assign tie        = tie_q;
  assign busy       = (state_q == HOLD);
endmodule
